// File: rtl/branch_predictor_pkg.sv
// Shared widths, 2-bit counter encodings and update-action decode for the
// fetch-stage branch predictor.
package branch_predictor_pkg;

   localparam int unsigned REG_W    = 32;
   localparam int unsigned BP_IDX_W = 5;
   localparam int unsigned BP_TAG_W = 8;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   typedef enum logic [1:0] {
      UPD_NONE,
      UPD_ALLOC,
      UPD_TRAIN,
      UPD_INVAL
   } upd_act_e;

   // What a resolved instruction does to the entry at its index.
   function automatic upd_act_e decode_upd(input logic is_branch,
                                           input logic hit,
                                           input logic taken);
      upd_act_e act;
      act = UPD_NONE;
      if (is_branch) begin
         if (hit)        act = UPD_TRAIN;
         else if (taken) act = UPD_ALLOC;
      end else if (hit) begin
         act = UPD_INVAL;
      end
      return act;
   endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Combinational next value of a 2-bit saturating direction counter.
module bp_sat_ctr2
   import branch_predictor_pkg::*;
(
   input  ctr_e ctr_i,
   input  logic taken_i,
   output ctr_e ctr_o
);

   // Step toward ST on taken, toward SNT on not-taken, clamping at the ends.
   always_comb begin
      ctr_o = ctr_i;
      unique case (ctr_i)
         CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
         CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
         CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
         CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
         default: ctr_o = ctr_i;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters. Combinational lookup for
// the fetch PC, single write port trained by ID, saturating perf counters.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int unsigned IDX_W  = BP_IDX_W,
   parameter int unsigned TAG_W  = BP_TAG_W,
   parameter int unsigned PERF_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [REG_W-1:0]  if_predict_pc_i,
   output logic              if_predict_taken_o,
   output logic [REG_W-1:0]  if_predict_targetPc_o,
   input  logic              lookup_valid_i,
   input  logic              upd_valid_i,
   input  logic [REG_W-1:0]  upd_pc_i,
   input  logic              upd_is_branch_i,
   input  logic              upd_uncond_i,
   input  logic              upd_taken_i,
   input  logic [REG_W-1:0]  upd_target_i,
   input  logic              upd_mispredict_i,
   input  logic              flush_i,
   output logic [PERF_W-1:0] perf_lookup_o,
   output logic [PERF_W-1:0] perf_hit_o,
   output logic [PERF_W-1:0] perf_mispredict_o
);

   localparam int unsigned ENTRIES = 1 << IDX_W;

   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] uncond_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [REG_W-1:0]   target_q [ENTRIES];
   ctr_e               ctr_q    [ENTRIES];

   logic [IDX_W-1:0]   lk_idx;
   logic [TAG_W-1:0]   lk_tag;
   logic               lk_hit;

   logic [IDX_W-1:0]   up_idx;
   logic [TAG_W-1:0]   up_tag;
   logic               up_hit;
   upd_act_e           up_act;
   ctr_e               ctr_nxt;

   logic [PERF_W-1:0]  perf_lookup_q;
   logic [PERF_W-1:0]  perf_hit_q;
   logic [PERF_W-1:0]  perf_mispredict_q;

   logic               unused_pc_bits;

   assign unused_pc_bits = ^{if_predict_pc_i[1:0], if_predict_pc_i[REG_W-1:IDX_W+TAG_W+2],
                             upd_pc_i[1:0], upd_pc_i[REG_W-1:IDX_W+TAG_W+2]};

   // Fetch-side lookup: purely combinational, no bypass of a same-cycle update.
   always_comb begin
      lk_idx                = if_predict_pc_i[IDX_W+1:2];
      lk_tag                = if_predict_pc_i[IDX_W+TAG_W+1:IDX_W+2];
      lk_hit                = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      if_predict_taken_o    = lk_hit && (uncond_q[lk_idx] || ctr_q[lk_idx][1]);
      if_predict_targetPc_o = if_predict_taken_o ? target_q[lk_idx] : '0;
   end

   // Update-side decode of the indexed entry against the resolved instruction.
   always_comb begin
      up_idx = upd_pc_i[IDX_W+1:2];
      up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
      up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      up_act = decode_upd(upd_is_branch_i, up_hit, upd_taken_i);
   end

   bp_sat_ctr2 u_sat_ctr (
      .ctr_i   (ctr_q[up_idx]),
      .taken_i (upd_taken_i),
      .ctr_o   (ctr_nxt)
   );

   // Entry storage: flush has priority over a same-cycle update.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q  <= '0;
         uncond_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
      end else if (flush_i) begin
         valid_q <= '0;
      end else if (upd_valid_i) begin
         unique case (up_act)
            UPD_ALLOC: begin
               valid_q[up_idx]  <= 1'b1;
               tag_q[up_idx]    <= up_tag;
               target_q[up_idx] <= upd_target_i;
               uncond_q[up_idx] <= upd_uncond_i;
               ctr_q[up_idx]    <= CTR_WT;
            end
            UPD_TRAIN: begin
               ctr_q[up_idx]    <= ctr_nxt;
               uncond_q[up_idx] <= upd_uncond_i;
               if (upd_taken_i) target_q[up_idx] <= upd_target_i;
            end
            UPD_INVAL: valid_q[up_idx] <= 1'b0;
            default: ;
         endcase
      end
   end

   // Performance counters, each saturating at all-ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_lookup_q     <= '0;
         perf_hit_q        <= '0;
         perf_mispredict_q <= '0;
      end else begin
         if (lookup_valid_i && (perf_lookup_q != '1))
            perf_lookup_q <= perf_lookup_q + 1'b1;
         if (lookup_valid_i && lk_hit && (perf_hit_q != '1))
            perf_hit_q <= perf_hit_q + 1'b1;
         if (upd_valid_i && upd_mispredict_i && (perf_mispredict_q != '1))
            perf_mispredict_q <= perf_mispredict_q + 1'b1;
      end
   end

   assign perf_lookup_o     = perf_lookup_q;
   assign perf_hit_o        = perf_hit_q;
   assign perf_mispredict_o = perf_mispredict_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: expectations are queued as
// stimulus is driven and drained against the DUT mid-cycle.
module tb_branch_predictor;
   import branch_predictor_pkg::*;

   localparam int unsigned PW = 8;  // narrow perf counters so saturation is reachable

   logic              clk = 1'b0;
   logic              rst_n;
   logic [REG_W-1:0]  pc;
   logic              taken;
   logic [REG_W-1:0]  target;
   logic              lookup_valid;
   logic              upd_valid;
   logic [REG_W-1:0]  upd_pc;
   logic              upd_is_branch;
   logic              upd_uncond;
   logic              upd_taken;
   logic [REG_W-1:0]  upd_target;
   logic              upd_mispredict;
   logic              flush;
   logic [PW-1:0]     perf_lookup;
   logic [PW-1:0]     perf_hit;
   logic [PW-1:0]     perf_mispredict;

   always #5 clk = ~clk;

   branch_predictor #(.IDX_W(5), .TAG_W(8), .PERF_W(PW)) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .if_predict_pc_i       (pc),
      .if_predict_taken_o    (taken),
      .if_predict_targetPc_o (target),
      .lookup_valid_i        (lookup_valid),
      .upd_valid_i           (upd_valid),
      .upd_pc_i              (upd_pc),
      .upd_is_branch_i       (upd_is_branch),
      .upd_uncond_i          (upd_uncond),
      .upd_taken_i           (upd_taken),
      .upd_target_i          (upd_target),
      .upd_mispredict_i      (upd_mispredict),
      .flush_i               (flush),
      .perf_lookup_o         (perf_lookup),
      .perf_hit_o            (perf_hit),
      .perf_mispredict_o     (perf_mispredict)
   );

   typedef enum int {S_TAKEN, S_TARGET, S_LOOKUP, S_HIT, S_MISP} sel_e;
   typedef struct {
      string       tag;
      sel_e        sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input sel_e sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic drain_sb();
      exp_t        e;
      logic [31:0] got;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            S_TAKEN:  got = {31'b0, taken};
            S_TARGET: got = target;
            S_LOOKUP: got = 32'(perf_lookup);
            S_HIT:    got = 32'(perf_hit);
            default:  got = 32'(perf_mispredict);
         endcase
         chk_val(e.tag, got, e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_upd();
      upd_valid      = 1'b0;
      upd_pc         = '0;
      upd_is_branch  = 1'b0;
      upd_uncond     = 1'b0;
      upd_taken      = 1'b0;
      upd_target     = '0;
      upd_mispredict = 1'b0;
      flush          = 1'b0;
   endtask

   task automatic look(input string tag, input logic [31:0] a, input logic t, input logic [31:0] tgt);
      pc           = a;
      lookup_valid = 1'b0;
      push_exp({tag, ".taken"}, S_TAKEN, {31'b0, t});
      push_exp({tag, ".target"}, S_TARGET, tgt);
      @(negedge clk);
      drain_sb();
      tick();
   endtask

   task automatic perf(input string tag, input logic [31:0] l, input logic [31:0] h, input logic [31:0] m);
      push_exp({tag, ".lookup"}, S_LOOKUP, l);
      push_exp({tag, ".hit"}, S_HIT, h);
      push_exp({tag, ".misp"}, S_MISP, m);
      drain_sb();
   endtask

   task automatic upd(input logic [31:0] a, input logic isb, input logic unc,
                      input logic tkn, input logic [31:0] tgt);
      upd_valid     = 1'b1;
      upd_pc        = a;
      upd_is_branch = isb;
      upd_uncond    = unc;
      upd_taken     = tkn;
      upd_target    = tgt;
      tick();
      clr_upd();
   endtask

   localparam logic [31:0] PA = 32'h1c00_0010;  // idx 4, tag 0x00
   localparam logic [31:0] PB = 32'h1c00_0090;  // idx 4, tag 0x01
   localparam logic [31:0] PC = 32'h1c00_0020;  // idx 8
   localparam logic [31:0] PD = 32'h1c00_0040;  // idx 16

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      pc           = '0;
      lookup_valid = 1'b0;
      clr_upd();

      // Reset state
      tick();
      tick();
      pc = 32'h1c00_0000;
      push_exp("rst.taken", S_TAKEN, 0);
      push_exp("rst.target", S_TARGET, 0);
      perf("rst", 0, 0, 0);
      rst_n = 1'b1;
      tick();

      // Three consumed lookups on an empty table
      for (int i = 0; i < 3; i++) begin
         pc           = 32'h1c00_0000;
         lookup_valid = 1'b1;
         push_exp("empty.taken", S_TAKEN, 0);
         push_exp("empty.target", S_TARGET, 0);
         @(negedge clk);
         drain_sb();
         tick();
      end
      lookup_valid = 1'b0;
      perf("t1", 3, 0, 0);

      // Allocate; same-cycle lookup sees old state
      pc            = PA;
      upd_valid     = 1'b1;
      upd_pc        = PA;
      upd_is_branch = 1'b1;
      upd_taken     = 1'b1;
      upd_target    = 32'h1c00_0100;
      push_exp("nobypass.taken", S_TAKEN, 0);
      push_exp("nobypass.target", S_TARGET, 0);
      @(negedge clk);
      drain_sb();
      tick();
      clr_upd();
      lookup_valid = 1'b1;
      push_exp("alloc.taken", S_TAKEN, 1);
      push_exp("alloc.target", S_TARGET, 32'h1c00_0100);
      @(negedge clk);
      drain_sb();
      tick();
      lookup_valid = 1'b0;
      perf("t2", 4, 1, 0);

      // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10
      upd(PA, 1, 0, 0, 0);               look("nt1", PA, 0, 0);
      upd(PA, 1, 0, 0, 0);               look("nt2", PA, 0, 0);
      upd(PA, 1, 0, 0, 0);               look("nt3", PA, 0, 0);
      upd(PA, 1, 0, 1, 32'h1c00_0100);   look("t1", PA, 0, 0);
      upd(PA, 1, 0, 1, 32'h1c00_0100);   look("t2", PA, 1, 32'h1c00_0100);
      // Unconditional overrides a weak counter (10 -> 01 here)
      upd(PA, 1, 1, 0, 0);               look("uncond", PA, 1, 32'h1c00_0100);
      // Back to conditional; saturate high then step down: 01->10->11->11->10->01
      upd(PA, 1, 0, 1, 32'h1c00_0100);   look("c10", PA, 1, 32'h1c00_0100);
      upd(PA, 1, 0, 1, 32'h1c00_0100);
      upd(PA, 1, 0, 1, 32'h1c00_0100);
      upd(PA, 1, 0, 0, 0);               look("sat_hi", PA, 1, 32'h1c00_0100);
      upd(PA, 1, 0, 0, 0);               look("c01", PA, 0, 0);
      upd(PA, 1, 0, 1, 32'h1c00_0100);   look("c10b", PA, 1, 32'h1c00_0100);

      // Aliasing at index 4
      look("alias.miss", PB, 0, 0);
      upd(PB, 1, 0, 0, 0);               look("alias.nt", PA, 1, 32'h1c00_0100);
      upd(PB, 1, 0, 1, 32'h1c00_0200);
      look("alias.evict", PA, 0, 0);
      look("alias.new", PB, 1, 32'h1c00_0200);
      upd(PB, 0, 0, 0, 0);               look("alias.inval", PB, 0, 0);

      // Flush beats a same-cycle allocation
      upd(PC, 1, 0, 1, 32'h1c00_0300);   look("pc.hit", PC, 1, 32'h1c00_0300);
      flush = 1'b1;
      upd(PA, 1, 0, 1, 32'h1c00_0100);
      look("flush.pc", PC, 0, 0);
      look("flush.pa", PA, 0, 0);

      // Mispredict counting, gated by upd_valid
      upd_mispredict = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         upd_valid      = 1'b1;
         upd_pc         = 32'h1c00_0ffc;
         upd_mispredict = 1'b1;
         tick();
      end
      clr_upd();
      perf("t5", 4, 1, 4);

      // Asynchronous reset mid-update aborts the write
      upd(PC, 1, 0, 1, 32'h1c00_0300);
      pc            = PC;
      upd_valid     = 1'b1;
      upd_pc        = PD;
      upd_is_branch = 1'b1;
      upd_taken     = 1'b1;
      upd_target    = 32'h1c00_0400;
      #2;
      push_exp("prerst.taken", S_TAKEN, 1);
      push_exp("prerst.target", S_TARGET, 32'h1c00_0300);
      drain_sb();
      #1;
      rst_n = 1'b0;
      #1;
      push_exp("arst.taken", S_TAKEN, 0);
      push_exp("arst.target", S_TARGET, 0);
      perf("arst", 0, 0, 0);
      tick();
      @(negedge clk);
      clr_upd();
      rst_n = 1'b1;
      tick();
      look("arst.pd", PD, 0, 0);
      look("arst.pc", PC, 0, 0);

      // Saturation of all perf counters
      upd(PC, 1, 0, 1, 32'h1c00_0300);
      for (int i = 0; i < 300; i++) begin
         pc             = PC;
         lookup_valid   = 1'b1;
         upd_valid      = 1'b1;
         upd_pc         = 32'h1c00_0ffc;
         upd_mispredict = 1'b1;
         tick();
      end
      lookup_valid = 1'b0;
      clr_upd();
      perf("sat", 32'hff, 32'hff, 32'hff);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
